// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine with a running signed-maximum tracker.
// Each word costs one READ cycle, which captures the combinational readData,
// and one WRITE cycle, which stores that word at the destination.
// The outputs are decoded from the registered state, index and data word.
module mem_copy_master #(
    parameter int CNT_W      = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      srcAddr,
    input  logic [31:0]      dstAddr,
    input  logic [CNT_W-1:0] count,
    output logic             memRead,
    output logic             memWrite,
    output logic [31:0]      Address,
    output logic [31:0]      writeData,
    input  logic [31:0]      readData,
    output logic             busy,
    output logic             done,
    output logic [31:0]      maxVal,
    output logic [CNT_W-1:0] maxIdx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [31:0]      src_q,     src_d;
    logic [31:0]      dst_q,     dst_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] idx_q,     idx_d;
    logic [31:0]      data_q,    data_d;
    logic [31:0]      max_val_q, max_val_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;

    logic [31:0]      word_off_s;
    logic [CNT_W-1:0] last_idx_s;

    // Byte offset of the current word; 32-bit arithmetic wraps silently.
    always_comb begin
        word_off_s = 32'(idx_q) * 32'(WORD_BYTES);
        last_idx_s = cnt_q - CNT_W'(1);
    end

    // State register and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= 32'h0000_0000;
            dst_q     <= 32'h0000_0000;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= 32'h0000_0000;
            max_val_q <= 32'h0000_0000;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    // Next-state logic: launch, word sequencing and max tracking.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d     = srcAddr;
                    dst_d     = dstAddr;
                    cnt_d     = count;
                    idx_d     = '0;
                    max_val_d = 32'h0000_0000;
                    max_idx_d = '0;
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                data_d = readData;
                // Word 0 always seeds the max; later words need a strict
                // signed win, so ties keep the earliest index.
                if ((idx_q == '0) || ($signed(readData) > $signed(max_val_q))) begin
                    max_val_d = readData;
                    max_idx_d = idx_q;
                end else begin
                    max_val_d = max_val_q;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == last_idx_s) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state; idle buses are held at zero.
    always_comb begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        Address   = 32'h0000_0000;
        writeData = 32'h0000_0000;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_READ: begin
                memRead = 1'b1;
                Address = src_q + word_off_s;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                memWrite  = 1'b1;
                Address   = dst_q + word_off_s;
                writeData = data_q;
                busy      = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign maxVal = max_val_q;
    assign maxIdx = max_idx_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: a small word memory, a sequential copy model
// and a per-cycle monitor of strobes, done and busy.
module tb_mem_copy_master;

    localparam int CNT_W = 16;
    localparam int MW    = 1024;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      srcAddr;
    logic [31:0]      dstAddr;
    logic [CNT_W-1:0] count;
    logic             memRead;
    logic             memWrite;
    logic [31:0]      Address;
    logic [31:0]      writeData;
    logic [31:0]      readData;
    logic             busy;
    logic             done;
    logic [31:0]      maxVal;
    logic [CNT_W-1:0] maxIdx;

    logic [31:0] mem [0:MW-1];
    logic [31:0] model_mem [0:MW-1];
    logic        tb_clr;
    logic        tb_we;
    logic [9:0]  tb_wa;
    logic [31:0] tb_wd;

    int n_checks = 0;
    int n_errors = 0;

    mem_copy_master #(.CNT_W(CNT_W), .WORD_BYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .srcAddr(srcAddr), .dstAddr(dstAddr), .count(count),
        .memRead(memRead), .memWrite(memWrite), .Address(Address),
        .writeData(writeData), .readData(readData),
        .busy(busy), .done(done), .maxVal(maxVal), .maxIdx(maxIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory aliases on address bits [11:2]; reads are combinational.
    assign readData = mem[Address[11:2]];

    // Memory write port shared by the DUT and the bench loader.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int k = 0; k < MW; k++) mem[k] <= 32'h0;
        end else if (memWrite) begin
            mem[Address[11:2]] <= writeData;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a[11:2]; tb_wd = v;
        model_mem[a[11:2]] = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic mem_cmp(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < MW; k++) if (mem[k] !== model_mem[k]) bad++;
        chk_eq({tag, "_mem"}, bad, 0);
    endtask

    // One transfer: start at edge 0, then watch 2n+6 cycles. Optional start
    // pulses at cycles pa/pb and a reset in cycle rst_at (0 = none).
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int pa, input int pb, input int rst_at, input string tag);
        logic [31:0] e_rd[$], e_wa[$], e_wd[$];
        logic [31:0] rd_a[$], wr_a[$], wr_d[$];
        logic [31:0] ea, w, mx;
        int mi, copied, exp_done, ncyc, done_cnt, done_cyc, late, idle_bad, both;
        copied = (rst_at > 0) ? (rst_at - 1) / 2 : n;
        if (copied > n) copied = n;
        mx = 32'h0; mi = 0;
        for (int i = 0; i < copied; i++) begin
            ea = s + 32'(4 * i);
            w  = model_mem[ea[11:2]];
            if (i == 0 || $signed(w) > $signed(mx)) begin mx = w; mi = i; end
            e_rd.push_back(ea);
            ea = d + 32'(4 * i);
            e_wa.push_back(ea);
            e_wd.push_back(w);
            model_mem[ea[11:2]] = w;
        end
        exp_done = (n == 0) ? 1 : 2 * n + 1;
        ncyc = 2 * n + 6;
        done_cnt = 0; done_cyc = -1; late = 0; idle_bad = 0; both = 0;
        @(negedge clk);
        start = 1'b1; srcAddr = s; dstAddr = d; count = CNT_W'(n);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (memRead && memWrite) both++;
            if (!memRead && !memWrite && (Address !== 32'h0 || writeData !== 32'h0)) idle_bad++;
            if (memRead)  rd_a.push_back(Address);
            if (memWrite) begin wr_a.push_back(Address); wr_d.push_back(writeData); end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (rst_at > 0 && c > rst_at && (memRead || memWrite || done)) late++;
            if (rst_at > 0 && c == rst_at + 1) begin
                chk_eq({tag, "_rst_ctl"}, {28'h0, memRead, memWrite, busy, done}, 32'h0);
                chk_eq({tag, "_rst_addr"}, Address, 32'h0);
                chk_eq({tag, "_rst_wd"}, writeData, 32'h0);
                chk_eq({tag, "_rst_max"}, maxVal, 32'h0);
                chk_eq({tag, "_rst_idx"}, 32'(maxIdx), 32'h0);
            end
            if (c == 1) chk_eq({tag, "_busy_on"}, 32'(busy), 32'h1);
            if (rst_at == 0 && c == exp_done + 1) chk_eq({tag, "_busy_off"}, 32'(busy), 32'h0);
            start   = (c == pa) || (c == pb);
            srcAddr = $urandom; dstAddr = $urandom; count = CNT_W'($urandom);
            rst     = (c == rst_at);
        end
        start = 1'b0;
        chk_eq({tag, "_excl"}, both, 0);
        chk_eq({tag, "_idle_bus"}, idle_bad, 0);
        chk_eq({tag, "_wr_n"}, wr_a.size(), e_wa.size());
        for (int i = 0; i < e_wa.size() && i < wr_a.size(); i++) begin
            chk_eq({tag, "_wr_a"}, wr_a[i], e_wa[i]);
            chk_eq({tag, "_wr_d"}, wr_d[i], e_wd[i]);
        end
        if (rst_at > 0) begin
            chk_eq({tag, "_late"}, late, 0);
            chk_eq({tag, "_done_n"}, done_cnt, 0);
        end else begin
            chk_eq({tag, "_rd_n"}, rd_a.size(), e_rd.size());
            for (int i = 0; i < e_rd.size() && i < rd_a.size(); i++)
                chk_eq({tag, "_rd_a"}, rd_a[i], e_rd[i]);
            chk_eq({tag, "_done_n"}, done_cnt, 1);
            chk_eq({tag, "_done_cyc"}, done_cyc, exp_done);
            chk_eq({tag, "_maxval"}, maxVal, mx);
            chk_eq({tag, "_maxidx"}, 32'(maxIdx), 32'(mi));
        end
        mem_cmp(tag);
    endtask

    initial begin
        logic [31:0] d35 [10];
        logic [31:0] s, d;
        int n;
        d35 = '{32'd56, 32'd5, 32'd4, 32'd6, 32'd1, 32'd5, 32'd4, 32'd8, 32'd4, 32'd5};
        rst = 1'b1; start = 1'b1; srcAddr = 32'd1000; dstAddr = 32'd2000; count = 16'd5;
        tb_clr = 1'b1; tb_we = 1'b0; tb_wa = 10'd0; tb_wd = 32'h0;
        for (int k = 0; k < MW; k++) model_mem[k] = 32'h0;
        repeat (3) @(negedge clk);
        tb_clr = 1'b0;
        chk_eq("rst_ctl", {28'h0, memRead, memWrite, busy, done}, 32'h0);
        chk_eq("rst_addr", Address, 32'h0);
        chk_eq("rst_wd", writeData, 32'h0);
        chk_eq("rst_max", maxVal, 32'h0);
        chk_eq("rst_idx", 32'(maxIdx), 32'h0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_eq("rst_start_idle", 32'(busy), 32'h0);

        for (int i = 0; i < 10; i++) poke(32'd1000 + 32'(4 * i), d35[i]);
        run_xfer(32'd1000, 32'd2000, 10, 0, 0, 0, "copy");
        chk_eq("copy_max56", maxVal, 32'd56);
        chk_eq("copy_idx0", 32'(maxIdx), 32'd0);

        run_xfer(32'd3000, 32'd3100, 0, 0, 0, 0, "zero");
        chk_eq("zero_max", maxVal, 32'd0);

        poke(32'd400, 32'hFFFF_FFFD); poke(32'd404, 32'hFFFF_FFFF); poke(32'd408, 32'hFFFF_FFFF);
        run_xfer(32'd400, 32'd600, 3, 0, 0, 0, "signed");
        chk_eq("signed_max", maxVal, 32'hFFFF_FFFF);
        chk_eq("signed_idx", 32'(maxIdx), 32'd1);

        poke(32'hFFFF_FFFC, 32'h1234_5678); poke(32'h0000_0000, 32'h8000_0001);
        run_xfer(32'hFFFF_FFFC, 32'd100, 2, 0, 0, 0, "wrap");

        for (int i = 0; i < 4; i++) poke(32'd1200 + 32'(4 * i), $urandom);
        run_xfer(32'd1200, 32'd1400, 4, 3, 9, 0, "busy_start");

        run_xfer(32'd1000, 32'd2400, 10, 0, 0, 5, "abort");
        run_xfer(32'd1000, 32'd2800, 10, 0, 0, 0, "after_abort");

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 12);
            s = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, MW - 1)) << 2);
            d = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, MW - 1)) << 2);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) poke(s + 32'(4 * i), 32'(d35[$urandom_range(0, 9)]));
                else poke(s + 32'(4 * i), $urandom);
            end
            run_xfer(s, d, n, 0, 0, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
